// File: rtl/btn_ctrl_pkg.sv
// Package: btn_ctrl_pkg
// Shared types and default timing constants for the push-button conditioning path.
//  btn_state_t   debounce FSM state encoding (IDLE, ARM, PRESSED, DISARM)
//  DEBOUNCE_DEF  default stable-cycle count before a level change is accepted (10 ms @ 100 MHz)
//  LONG_DEF      default hold-cycle count before a long press fires (1 s @ 100 MHz)
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    DISARM  = 2'd3
  } btn_state_t;

  localparam int unsigned DEBOUNCE_DEF = 1_000_000;
  localparam int unsigned LONG_DEF     = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Module: sync_2ff
// Generic 1-bit two-flop synchroniser for signals asynchronous to clk.
// Only q may be used downstream; the first stage may go metastable.
//  clk    in  1  destination clock, rising edge
//  reset  in  1  asynchronous, active-high; clears both stages
//  d      in  1  asynchronous input
//  q      out 1  synchronised output, two clk edges after d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_sel_conditioner.sv
// Module: btn_sel_conditioner
// Conditions the raw board push-button feeding the blink counter's sel input:
// synchronises it, debounces it with a counter-qualified FSM, and produces a
// sel level that toggles once per accepted press plus one-cycle event strobes.
// Optional feature macro: BTN_LONGPRESS_EN -- when defined, a press held for
// LONG_CYCLES fires long_pulse and forces sel_out low; when undefined the hold
// counter is not built and long_pulse is tied low.
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high
//  btn_in       in   1  raw button, asynchronous to clk, active-high
//  btn_level    out  1  debounced button level
//  press_pulse  out  1  one-cycle strobe on each accepted press
//  long_pulse   out  1  one-cycle strobe when a press is held LONG_CYCLES
//  sel_out      out  1  toggled select level for the counter's sel input
module btn_sel_conditioner
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic long_pulse,
  output logic sel_out
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counter widths and FSM cannot honour.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
    $error("btn_sel_conditioner: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  logic btn_s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  btn_state_t    state, state_next;
  logic [DW-1:0] dcnt, dcnt_next;
  logic          level_next, press_next, sel_next;

`ifdef BTN_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HCNT_LONG = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hcnt, hcnt_next;
  logic          long_next;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    level_next = btn_level;
    sel_next   = sel_out;
    press_next = 1'b0;
`ifdef BTN_LONGPRESS_EN
    hcnt_next  = hcnt;
    long_next  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_next = ARM;
          dcnt_next  = '0;
        end
      end
      ARM: begin
        if (!btn_s) begin
          state_next = IDLE;             // bounce rejected
        end else if (dcnt == DCNT_LAST) begin
          state_next = PRESSED;
          level_next = 1'b1;
          press_next = 1'b1;
          sel_next   = ~sel_out;
`ifdef BTN_LONGPRESS_EN
          hcnt_next  = '0;
`endif
        end else begin
          dcnt_next = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next = DISARM;
          dcnt_next  = '0;
        end else begin
`ifdef BTN_LONGPRESS_EN
          // Saturation at LONG_CYCLES means HCNT_LONG is passed once per press,
          // so long_pulse cannot re-fire until a fresh press clears hcnt.
          if (hcnt != HCNT_MAX) hcnt_next = hcnt + 1'b1;
          if (hcnt == HCNT_LONG) begin
            long_next = 1'b1;
            sel_next  = 1'b0;
          end
`endif
        end
      end
      DISARM: begin
        // hcnt is left untouched here: a release bounce resumes the hold count.
        if (btn_s) begin
          state_next = PRESSED;
        end else if (dcnt == DCNT_LAST) begin
          state_next = IDLE;
          level_next = 1'b0;
        end else begin
          dcnt_next = dcnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dcnt        <= '0;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
      sel_out     <= 1'b0;
    end else begin
      state       <= state_next;
      dcnt        <= dcnt_next;
      btn_level   <= level_next;
      press_pulse <= press_next;
      sel_out     <= sel_next;
    end
  end

`ifdef BTN_LONGPRESS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      hcnt       <= hcnt_next;
      long_pulse <= long_next;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_sel_conditioner.sv
// Testbench: tb_btn_sel_conditioner
// Directed checks of btn_sel_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Edge numbering in comments: "edge 0" is the edge just before btn_in changes.
module tb_btn_sel_conditioner;
  import btn_ctrl_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level, press_pulse, long_pulse, sel_out;

  btn_sel_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .long_pulse  (long_pulse),
    .sel_out     (sel_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Running pulse tallies, sampled mid-cycle; tests compare differences.
  int press_total = 0;
  int long_total  = 0;
  always @(negedge clk) begin
    if (press_pulse) press_total++;
    if (long_pulse)  long_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int p0, l0;

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;

    // 1. Reset held with a toggling button, then release with button low.
    for (int i = 0; i < 6; i++) begin
      btn_in = ~btn_in;
      tick();
    end
    check("reset_outs", {btn_level, press_pulse, long_pulse, sel_out}, 4'b0000);
    btn_in = 1'b0;
    tick();
    reset = 1'b0;
    tick(10);
    check("idle_outs", {btn_level, press_pulse, long_pulse, sel_out}, 4'b0000);
    check("idle_state", 32'(dut.state), 32'(IDLE));

    // 2. Clean press: pulse and toggle after edge 3+DEB = 7.
    btn_in = 1'b1;
    tick(6);
    check("p_e6_pulse", press_pulse, 1'b0);
    check("p_e6_sel", sel_out, 1'b0);
    check("p_e6_state", 32'(dut.state), 32'(ARM));
    tick();
    check("p_e7_pulse", press_pulse, 1'b1);
    check("p_e7_sel", sel_out, 1'b1);
    check("p_e7_level", btn_level, 1'b1);
    tick();
    check("p_e8_pulse", press_pulse, 1'b0);
    check("p_e8_state", 32'(dut.state), 32'(PRESSED));

    // Release: level falls DEB+3 = 7 edges later, no pulse.
    p0 = press_total;
    btn_in = 1'b0;
    tick(6);
    check("r_e6_level", btn_level, 1'b1);
    tick();
    check("r_e7_level", btn_level, 1'b0);
    tick(3);
    check("r_no_pulse", 32'(press_total - p0), 32'd0);
    check("r_state", 32'(dut.state), 32'(IDLE));

    // 3. Bounce: 3 high, 2 low, 3 high, low -- never debounced.
    p0 = press_total;
    btn_in = 1'b1; tick(3);
    btn_in = 1'b0; tick(2);
    btn_in = 1'b1; tick(3);
    btn_in = 1'b0; tick(12);
    check("b_pulses", 32'(press_total - p0), 32'd0);
    check("b_sel", sel_out, 1'b1);
    check("b_level", btn_level, 1'b0);
    check("b_state", 32'(dut.state), 32'(IDLE));

    // 4. Two clean presses from sel=0: 0 -> 1 -> 0.
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    check("t_sel0", sel_out, 1'b0);
    p0 = press_total;
    btn_in = 1'b1; tick(10);
    check("t_sel1", sel_out, 1'b1);
    check("t_level1", btn_level, 1'b1);
    btn_in = 1'b0; tick(10);
    check("t_level0", btn_level, 1'b0);
    btn_in = 1'b1; tick(10);
    check("t_sel2", sel_out, 1'b0);
    btn_in = 1'b0; tick(10);
    check("t_pulses", 32'(press_total - p0), 32'd2);

    // 5. Long hold of 30 cycles; PRESSED entered at edge 7.
    p0 = press_total;
    l0 = long_total;
    btn_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 7) check("l_e7_sel", sel_out, 1'b1);
`ifdef BTN_LONGPRESS_EN
      if (k == 26) check("l_e26_long", long_pulse, 1'b0);
      if (k == 27) begin
        check("l_e27_long", long_pulse, 1'b1);
        check("l_e27_sel", sel_out, 1'b0);
      end
      if (k == 28) check("l_e28_long", long_pulse, 1'b0);
`else
      if (k == 30) check("l_e30_sel", sel_out, 1'b1);
`endif
    end
    btn_in = 1'b0;
    tick(12);
    check("l_press_cnt", 32'(press_total - p0), 32'd1);
`ifdef BTN_LONGPRESS_EN
    check("l_long_cnt", 32'(long_total - l0), 32'd1);
`else
    check("l_long_cnt", 32'(long_total - l0), 32'd0);
`endif

    // 6a. Async reset mid-PRESSED.
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    btn_in = 1'b1;
    tick(9);
    check("m_pressed", {btn_level, sel_out}, 2'b11);
    #3 reset = 1'b1;
    #1;
    check("m_p_outs", {btn_level, press_pulse, long_pulse, sel_out}, 4'b0000);
    check("m_p_state", 32'(dut.state), 32'(IDLE));
    tick();
    reset = 1'b0;

    // 6b. Async reset mid-ARM, then a fresh debounce with the button held.
    tick(5);
    check("m_arm", 32'(dut.state), 32'(ARM));
    #3 reset = 1'b1;
    #1;
    check("m_a_state", 32'(dut.state), 32'(IDLE));
    check("m_a_dcnt", 32'(dut.dcnt), 32'd0);
    tick();
    reset = 1'b0;
    tick(6);
    check("f_e6_pulse", press_pulse, 1'b0);
    tick();
    check("f_e7_pulse", press_pulse, 1'b1);
    check("f_e7_sel", sel_out, 1'b1);
    check("f_e7_level", btn_level, 1'b1);
    tick();
    check("f_e8_pulse", press_pulse, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
